regfile_sb: RTL and testbench

REGFILE_SB -- requirements
Module: regfile_sb

---
 rtl/regfile_sb_pkg.sv | 13 +
 rtl/regfile_sb_busy.sv | 59 +++++
 rtl/regfile_sb.sv | 91 +++++++++
 tb/tb_regfile_sb.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_sb_pkg.sv
// Shared register-file constants used by the register file and the decode unit.
// No logic; compile-time constants only.
// No flow control.
package regfile_sb_pkg;

    // Default geometry of the integer register file.
    localparam int RF_ADDR_WIDTH = 5;
    localparam int RF_DATA_WIDTH = 32;

    // Architectural index of the hardwired-zero register.
    localparam int RF_ZERO_IDX = 0;

endpackage

// File: rtl/regfile_sb_busy.sv
// Scoreboard: one busy bit per register plus a registered count of set bits.
// Busy bits and count update one cycle after issue/write-back.
// No backpressure; every issue and write-back is accepted on the edge.
module regfile_sb_busy
    import regfile_sb_pkg::*;
#(
    parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
    parameter int ZERO_REG   = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         issue_valid,
    input  logic [ADDR_WIDTH-1:0]        issue_rd,
    input  logic                         wen,
    input  logic [ADDR_WIDTH-1:0]        waddr,
    output logic [(2**ADDR_WIDTH)-1:0]   busy,
    output logic [ADDR_WIDTH:0]          busy_cnt
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic issue_ok;
    logic inc;
    logic dec;

    // An issue to the hardwired-zero register never creates a pending producer.
    assign issue_ok = issue_valid &&
                      !((ZERO_REG != 0) && (issue_rd == ADDR_WIDTH'(RF_ZERO_IDX)));

    // Count only real bit transitions: a re-issue to a busy index is not a 0->1,
    // and a write-back that collides with a new issue on the same index is not a 1->0.
    assign inc = issue_ok && !busy[issue_rd];
    assign dec = wen && busy[waddr] && !(issue_ok && (issue_rd == waddr));

    // Busy bits: issue sets, write-back clears, issue wins on a same-index collision.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (issue_ok && (issue_rd == ADDR_WIDTH'(i))) begin
                    busy[i] <= 1'b1;
                end else if (wen && (waddr == ADDR_WIDTH'(i))) begin
                    busy[i] <= 1'b0;
                end
            end
        end
    end

    // Running popcount of the busy bits, kept in step with the transitions above.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_cnt <= '0;
        end else begin
            busy_cnt <= busy_cnt + (ADDR_WIDTH+1)'(inc) - (ADDR_WIDTH+1)'(dec);
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// Two-read/one-write register file with write-through bypass and busy scoreboard.
// Reads are combinational (zero latency); writes and busy updates land on the edge.
// No backpressure; a same-cycle write-back unblocks a reader of that register.
module regfile_sb
    import regfile_sb_pkg::*;
#(
    parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
    parameter int DATA_WIDTH = RF_DATA_WIDTH,
    parameter int ZERO_REG   = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wen,
    input  logic [ADDR_WIDTH-1:0]  waddr,
    input  logic [DATA_WIDTH-1:0]  wdata,
    input  logic [ADDR_WIDTH-1:0]  raddr1,
    input  logic [ADDR_WIDTH-1:0]  raddr2,
    output logic [DATA_WIDTH-1:0]  rdata1,
    output logic [DATA_WIDTH-1:0]  rdata2,
    output logic                   busy1,
    output logic                   busy2,
    input  logic                   issue_valid,
    input  logic [ADDR_WIDTH-1:0]  issue_rd,
    output logic [ADDR_WIDTH:0]    busy_cnt
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = ADDR_WIDTH'(RF_ZERO_IDX);

    logic [DATA_WIDTH-1:0] rf [DEPTH];
    logic [DEPTH-1:0]      busy_vec;
    logic                  wr_ok;
    logic                  hit1;
    logic                  hit2;

    assign wr_ok = wen && !((ZERO_REG != 0) && (waddr == ZERO_IDX));
    assign hit1  = wen && (waddr == raddr1);
    assign hit2  = wen && (waddr == raddr2);

    regfile_sb_busy #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .ZERO_REG   (ZERO_REG)
    ) u_busy (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .wen         (wen),
        .waddr       (waddr),
        .busy        (busy_vec),
        .busy_cnt    (busy_cnt)
    );

    // Data array: write-back on the edge, register 0 left untouched when hardwired.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                rf[i] <= '0;
            end
        end else if (wr_ok) begin
            rf[waddr] <= wdata;
        end
    end

    // Read port 1: array, then bypass, then zero-register and reset override.
    always_comb begin
        rdata1 = rf[raddr1];
        busy1  = busy_vec[raddr1] && !hit1;
        if (hit1) begin
            rdata1 = wdata;
        end
        if (((ZERO_REG != 0) && (raddr1 == ZERO_IDX)) || rst) begin
            rdata1 = '0;
            busy1  = 1'b0;
        end
    end

    // Read port 2: same priority as port 1.
    always_comb begin
        rdata2 = rf[raddr2];
        busy2  = busy_vec[raddr2] && !hit2;
        if (hit2) begin
            rdata2 = wdata;
        end
        if (((ZERO_REG != 0) && (raddr2 == ZERO_IDX)) || rst) begin
            rdata2 = '0;
            busy2  = 1'b0;
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
module tb_regfile_sb;

    logic        clk;
    logic        rst;
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  raddr1;
    logic [4:0]  raddr2;
    logic [31:0] rdata1;
    logic [31:0] rdata2;
    logic        busy1;
    logic        busy2;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic [5:0]  busy_cnt;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: architectural register contents and set of pending producers.
    logic [31:0] m_rf [32];
    bit          m_busy [32];

    regfile_sb dut (
        .clk         (clk),
        .rst         (rst),
        .wen         (wen),
        .waddr       (waddr),
        .wdata       (wdata),
        .raddr1      (raddr1),
        .raddr2      (raddr2),
        .rdata1      (rdata1),
        .rdata2      (rdata2),
        .busy1       (busy1),
        .busy2       (busy2),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .busy_cnt    (busy_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_rf[i]   = 32'h0;
            m_busy[i] = 1'b0;
        end
    endtask

    function automatic int model_count();
        int c = 0;
        for (int i = 0; i < 32; i++) c += int'(m_busy[i]);
        return c;
    endfunction

    function automatic logic [31:0] exp_rdata(input logic [4:0] ra);
        if (rst || ra == 5'd0) return 32'h0;
        if (wen && waddr == ra) return wdata;
        return m_rf[ra];
    endfunction

    function automatic logic exp_busy(input logic [4:0] ra);
        if (rst || ra == 5'd0) return 1'b0;
        if (wen && waddr == ra) return 1'b0;
        return m_busy[ra];
    endfunction

    // One rising edge; the model applies the architectural rules to the inputs it saw.
    task automatic tick();
        @(posedge clk);
        if (!rst) begin
            if (wen) begin
                if (waddr != 5'd0) m_rf[waddr] = wdata;
                m_busy[waddr] = 1'b0;
            end
            if (issue_valid && issue_rd != 5'd0) m_busy[issue_rd] = 1'b1;
        end
        #1;
    endtask

    task automatic idle();
        wen = 1'b0; waddr = '0; wdata = '0;
        issue_valid = 1'b0; issue_rd = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle(); raddr1 = 5'd3; raddr2 = 5'd4;
        model_reset();
        tick(); tick();
        wen = 1'b1; waddr = 5'd3; wdata = 32'hCAFEF00D;
        issue_valid = 1'b1; issue_rd = 5'd4;
        #2;
        n_cmp++; if (rdata1 !== 32'h0) begin n_fail++; $display("FAIL reset_rdata1: got %h expected 0", rdata1); end
        n_cmp++; if (busy2 !== 1'b0) begin n_fail++; $display("FAIL reset_busy2: got %b expected 0", busy2); end
        n_cmp++; if (busy_cnt !== 6'd0) begin n_fail++; $display("FAIL reset_busy_cnt: got %0d expected 0", busy_cnt); end
        tick();
        #1;
        n_cmp++; if (busy_cnt !== 6'd0) begin n_fail++; $display("FAIL reset_ignore_issue: got %0d expected 0", busy_cnt); end
        rst = 1'b0;
        idle();
        #2;
        n_cmp++; if (rdata1 !== 32'h0) begin n_fail++; $display("FAIL reset_ignore_write: got %h expected 0", rdata1); end
        n_cmp++; if (busy2 !== 1'b0) begin n_fail++; $display("FAIL reset_ignore_busy: got %b expected 0", busy2); end
    endtask

    task automatic test_bypass();
        idle();
        wen = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF;
        tick();
        idle(); raddr1 = 5'd5; raddr2 = 5'd6;
        #2;
        n_cmp++; if (rdata1 !== 32'hDEADBEEF) begin n_fail++; $display("FAIL write_read: got %h expected deadbeef", rdata1); end
        wen = 1'b1; waddr = 5'd5; wdata = 32'h12345678; raddr2 = 5'd5;
        #2;
        n_cmp++; if (rdata2 !== 32'h12345678) begin n_fail++; $display("FAIL bypass_rdata2: got %h expected 12345678", rdata2); end
        n_cmp++; if (rdata1 !== 32'h12345678) begin n_fail++; $display("FAIL bypass_rdata1: got %h expected 12345678", rdata1); end
        tick();
        idle();
    endtask

    task automatic test_zero_reg();
        idle();
        wen = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF; raddr1 = 5'd0;
        #2;
        n_cmp++; if (rdata1 !== 32'h0) begin n_fail++; $display("FAIL zero_bypass: got %h expected 0", rdata1); end
        tick();
        idle();
        #2;
        n_cmp++; if (rdata1 !== 32'h0) begin n_fail++; $display("FAIL zero_write: got %h expected 0", rdata1); end
        n_cmp++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL zero_busy: got %b expected 0", busy1); end
        issue_valid = 1'b1; issue_rd = 5'd0;
        tick();
        idle();
        #2;
        n_cmp++; if (busy_cnt !== 6'd0) begin n_fail++; $display("FAIL zero_issue_cnt: got %0d expected 0", busy_cnt); end
        n_cmp++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL zero_issue_busy: got %b expected 0", busy1); end
    endtask

    task automatic test_issue_writeback();
        logic [31:0] d;
        idle();
        issue_valid = 1'b1; issue_rd = 5'd7;
        tick();
        idle(); raddr1 = 5'd7;
        #2;
        n_cmp++; if (busy1 !== 1'b1) begin n_fail++; $display("FAIL issue_busy1: got %b expected 1", busy1); end
        n_cmp++; if (busy_cnt !== 6'd1) begin n_fail++; $display("FAIL issue_cnt: got %0d expected 1", busy_cnt); end
        d = $urandom;
        wen = 1'b1; waddr = 5'd7; wdata = d;
        #2;
        n_cmp++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL wb_unblock: got %b expected 0", busy1); end
        n_cmp++; if (rdata1 !== d) begin n_fail++; $display("FAIL wb_bypass: got %h expected %h", rdata1, d); end
        tick();
        idle();
        #2;
        n_cmp++; if (busy_cnt !== 6'd0) begin n_fail++; $display("FAIL wb_cnt: got %0d expected 0", busy_cnt); end
        n_cmp++; if (rdata1 !== d) begin n_fail++; $display("FAIL wb_data: got %h expected %h", rdata1, d); end
    endtask

    task automatic test_same_cycle();
        idle();
        issue_valid = 1'b1; issue_rd = 5'd3;
        tick();
        issue_valid = 1'b1; issue_rd = 5'd3; wen = 1'b1; waddr = 5'd3; wdata = 32'h33;
        tick();
        idle(); raddr1 = 5'd3; raddr2 = 5'd4;
        #2;
        n_cmp++; if (busy1 !== 1'b1) begin n_fail++; $display("FAIL collide_busy3: got %b expected 1", busy1); end
        n_cmp++; if (busy_cnt !== 6'd1) begin n_fail++; $display("FAIL collide_cnt: got %0d expected 1", busy_cnt); end
        issue_valid = 1'b1; issue_rd = 5'd4; wen = 1'b1; waddr = 5'd3; wdata = 32'h44;
        tick();
        idle(); raddr1 = 5'd3; raddr2 = 5'd4;
        #2;
        n_cmp++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL swap_busy3: got %b expected 0", busy1); end
        n_cmp++; if (busy2 !== 1'b1) begin n_fail++; $display("FAIL swap_busy4: got %b expected 1", busy2); end
        n_cmp++; if (busy_cnt !== 6'd1) begin n_fail++; $display("FAIL swap_cnt: got %0d expected 1", busy_cnt); end
        wen = 1'b1; waddr = 5'd4; wdata = 32'h4;
        tick();
        idle();
    endtask

    task automatic test_fill();
        idle();
        rst = 1'b1; model_reset();
        #2 rst = 1'b0;
        for (int r = 1; r < 32; r++) begin
            issue_valid = 1'b1; issue_rd = 5'(r);
            tick();
        end
        idle(); raddr1 = 5'd31; raddr2 = 5'd0;
        #2;
        n_cmp++; if (busy_cnt !== 6'd31) begin n_fail++; $display("FAIL fill_cnt: got %0d expected 31", busy_cnt); end
        n_cmp++; if (busy1 !== 1'b1) begin n_fail++; $display("FAIL fill_busy31: got %b expected 1", busy1); end
        issue_valid = 1'b1; issue_rd = 5'd9;
        tick();
        idle();
        #2;
        n_cmp++; if (busy_cnt !== 6'd31) begin n_fail++; $display("FAIL reissue_cnt: got %0d expected 31", busy_cnt); end
    endtask

    task automatic test_reset_mid();
        idle();
        rst = 1'b1; model_reset();
        #2 rst = 1'b0;
        wen = 1'b1; waddr = 5'd10; wdata = 32'hA5A5A5A5;
        tick();
        idle(); issue_valid = 1'b1; issue_rd = 5'd10;
        tick();
        idle(); raddr1 = 5'd10; raddr2 = 5'd10;
        #2;
        n_cmp++; if (rdata1 !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL mid_pre_data: got %h expected a5a5a5a5", rdata1); end
        n_cmp++; if (busy1 !== 1'b1) begin n_fail++; $display("FAIL mid_pre_busy: got %b expected 1", busy1); end
        #2 rst = 1'b1; model_reset();
        #1;
        n_cmp++; if (rdata1 !== 32'h0) begin n_fail++; $display("FAIL mid_rdata: got %h expected 0", rdata1); end
        n_cmp++; if (busy2 !== 1'b0) begin n_fail++; $display("FAIL mid_busy: got %b expected 0", busy2); end
        n_cmp++; if (busy_cnt !== 6'd0) begin n_fail++; $display("FAIL mid_cnt: got %0d expected 0", busy_cnt); end
        rst = 1'b0;
        #2;
        n_cmp++; if (rdata1 !== 32'h0) begin n_fail++; $display("FAIL mid_post_data: got %h expected 0", rdata1); end
        wen = 1'b1; waddr = 5'd10; wdata = 32'h600DF00D;
        tick();
        idle();
        #2;
        n_cmp++; if (rdata1 !== 32'h600DF00D) begin n_fail++; $display("FAIL mid_post_write: got %h expected 600df00d", rdata1); end
        n_cmp++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL mid_post_busy: got %b expected 0", busy1); end
    endtask

    task automatic test_random();
        logic [31:0] e1, e2;
        logic        b1, b2;
        for (int n = 0; n < 400; n++) begin
            wen         = ($urandom_range(0, 99) < 45);
            waddr       = 5'($urandom_range(0, 9));
            wdata       = $urandom;
            issue_valid = ($urandom_range(0, 99) < 50);
            issue_rd    = 5'($urandom_range(0, 9));
            raddr1      = 5'($urandom_range(0, 9));
            raddr2      = (n % 4 == 0) ? waddr : 5'($urandom_range(0, 31));
            #2;
            e1 = exp_rdata(raddr1); e2 = exp_rdata(raddr2);
            b1 = exp_busy(raddr1);  b2 = exp_busy(raddr2);
            n_cmp++; if (rdata1 !== e1) begin n_fail++; $display("FAIL rnd_rdata1 cyc %0d: got %h expected %h", n, rdata1, e1); end
            n_cmp++; if (rdata2 !== e2) begin n_fail++; $display("FAIL rnd_rdata2 cyc %0d: got %h expected %h", n, rdata2, e2); end
            n_cmp++; if (busy1 !== b1) begin n_fail++; $display("FAIL rnd_busy1 cyc %0d: got %b expected %b", n, busy1, b1); end
            n_cmp++; if (busy2 !== b2) begin n_fail++; $display("FAIL rnd_busy2 cyc %0d: got %b expected %b", n, busy2, b2); end
            n_cmp++; if (int'(busy_cnt) != model_count()) begin n_fail++; $display("FAIL rnd_cnt cyc %0d: got %0d expected %0d", n, busy_cnt, model_count()); end
            tick();
        end
        idle();
    endtask

    initial begin
        rst = 1'b1;
        raddr1 = '0; raddr2 = '0;
        idle();
        test_reset();
        test_bypass();
        test_zero_reg();
        test_issue_writeback();
        test_same_cycle();
        test_fill();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
